apb_prci: RTL and testbench



---
 rtl/prci_pkg.sv | 51 +++++
 rtl/prci_sync.sv | 21 ++
 rtl/apb_prci.sv | 135 +++++++++++++
 tb/tb_apb_prci.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/prci_pkg.sv
// prci_pkg: shared types, FSM states, register map, reset-cause codes and PnP IDs for apb_prci
package prci_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLD,
        RUN,
        DM_RST,
        SW_RST
    } state_t;

    localparam logic [11:0] REG_STATUS = 12'h000;
    localparam logic [11:0] REG_SWRST  = 12'h004;
    localparam logic [11:0] REG_CAUSE  = 12'h008;
    localparam logic [11:0] REG_HOLD   = 12'h00C;

    localparam logic [3:0] CAUSE_POR  = 4'h1;
    localparam logic [3:0] CAUSE_DM   = 4'h2;
    localparam logic [3:0] CAUSE_SW   = 4'h4;
    localparam logic [3:0] CAUSE_LOCK = 4'h8;

    localparam logic [15:0] PRCI_VID = 16'h00F1;
    localparam logic [15:0] PRCI_DID = 16'h0F10;

    typedef struct packed {
        logic [31:0] addr_start;
        logic [31:0] addr_end;
    } mapinfo_type;

    typedef struct packed {
        logic [15:0] vid;
        logic [15:0] did;
        logic [31:0] addr_start;
        logic [31:0] addr_end;
    } dev_config_type;

    typedef struct packed {
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        pwrite;
        logic        psel;
        logic        penable;
    } apb_in_type;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } apb_out_type;

endpackage

// File: rtl/prci_sync.sv
// prci_sync: sync_stages-deep synchronizer chain, cleared by synchronous active-low reset
module prci_sync #(
    parameter int sync_stages = 2
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_d,
    output logic o_q
);

    logic [sync_stages-1:0] sync_q, sync_d;

    // shift the asynchronous input one stage per clock
    always_comb sync_d = {sync_q[sync_stages-2:0], i_d};

    // every stage, including the first, is cleared by reset
    always_ff @(posedge i_clk) sync_q <= i_nrst ? sync_d : '0;

    assign o_q = sync_q[sync_stages-1];

endmodule

// File: rtl/apb_prci.sv
// apb_prci: reset sequencer with APB status/control; PRCI_LOCK_LOSS_RESET_EN makes PLL lock loss reset the SoC
module apb_prci import prci_pkg::*; #(
    parameter int hold_cycles = 16,
    parameter int sync_stages = 2
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    input  logic           i_pll_locked,
    input  logic           i_dmreset,
    input  mapinfo_type    i_mapinfo,
    output dev_config_type o_cfg,
    input  apb_in_type     i_apbi,
    output apb_out_type    o_apbo,
    output logic           o_sys_nrst,
    output logic           o_dbg_nrst
);

    localparam int CW = $clog2(hold_cycles);
    localparam logic [CW-1:0] CNT_MAX = CW'(hold_cycles - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          locked_s, locked_prev_q;
    logic          sys_q, sys_d, dbg_q, dbg_d, lost_q, lost_d;
    logic [3:0]    cause_q, cause_d;
    apb_out_type   apbo_q, apbo_d;
    logic [11:0]   off;
    logic [31:0]   rdata;
    logic          access, wr, bad, sw_req, clr_lost, lock_fall, loss, lock_rst;
    logic          unused;

    prci_sync #(.sync_stages(sync_stages)) u_sync (
        .i_clk (i_clk),
        .i_nrst(i_nrst),
        .i_d   (i_pll_locked),
        .o_q   (locked_s)
    );

    // APB decode: one wait state, response registered with the access
    always_comb begin
        off      = i_apbi.paddr[11:0] - i_mapinfo.addr_start[11:0];
        access   = i_apbi.psel & i_apbi.penable & ~apbo_q.pready;
        wr       = access & i_apbi.pwrite;
        bad      = ~(off inside {REG_STATUS, REG_SWRST, REG_CAUSE, REG_HOLD});
        rdata    = off == REG_STATUS ? {28'd0, dbg_q, sys_q, lost_q, locked_s} :
                   off == REG_CAUSE  ? {28'd0, cause_q} :
                   off == REG_HOLD   ? 32'(hold_cycles) : 32'd0;
        sw_req   = wr & (off == REG_SWRST) & i_apbi.pwdata[0];
        clr_lost = wr & (off == REG_STATUS) & i_apbi.pwdata[1];
        apbo_d.pready  = access;
        apbo_d.pslverr = access & bad;
        apbo_d.prdata  = (access & ~i_apbi.pwrite & ~bad) ? rdata : 32'd0;
    end

    // reset sequencing FSM; reset outputs follow the next state so they are registered
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        lock_fall = locked_prev_q & ~locked_s;
`ifdef PRCI_LOCK_LOSS_RESET_EN
        loss      = lock_fall & (state_q inside {RUN, DM_RST, SW_RST});
        lock_rst  = loss;
`else
        loss      = lock_fall & (state_q == RUN);
        lock_rst  = 1'b0;
`endif
        case (state_q)
            WAIT_LOCK: if (locked_s) begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                cnt_d = cnt_q + CW'(1);
                if (!locked_s) state_d = WAIT_LOCK;
                else if (cnt_q == CNT_MAX) state_d = RUN;
            end
            RUN: if (i_dmreset) begin
                state_d = DM_RST;
                cause_d = CAUSE_DM;
            end else if (sw_req) begin
                state_d = SW_RST;
                cnt_d   = '0;
                cause_d = CAUSE_SW;
            end
            DM_RST: if (!i_dmreset) begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            SW_RST: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_MAX) state_d = RUN;
            end
            default: state_d = WAIT_LOCK;
        endcase
        if (lock_rst) begin
            state_d = WAIT_LOCK;
            cause_d = CAUSE_LOCK;
        end
        sys_d  = state_d == RUN;
        dbg_d  = ~lock_rst & (dbg_q | sys_d);
        lost_d = loss | (lost_q & ~clr_lost);
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            locked_prev_q <= 1'b0;
            sys_q         <= 1'b0;
            dbg_q         <= 1'b0;
            lost_q        <= 1'b0;
            cause_q       <= CAUSE_POR;
            apbo_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            locked_prev_q <= locked_s;
            sys_q         <= sys_d;
            dbg_q         <= dbg_d;
            lost_q        <= lost_d;
            cause_q       <= cause_d;
            apbo_q        <= apbo_d;
        end
    end

    assign o_apbo     = apbo_q;
    assign o_sys_nrst = sys_q;
    assign o_dbg_nrst = dbg_q;
    assign o_cfg      = '{vid: PRCI_VID, did: PRCI_DID,
                          addr_start: i_mapinfo.addr_start, addr_end: i_mapinfo.addr_end};
    assign unused     = ^{i_apbi.paddr[31:12], i_apbi.pwdata[31:2]};

endmodule

// File: tb/tb_apb_prci.sv
// tb_apb_prci: directed stimulus with an APB response scoreboard for apb_prci
module tb_apb_prci;
    import prci_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_3100;
`ifdef PRCI_LOCK_LOSS_RESET_EN
    localparam logic [31:0] CAUSE_END = 32'h8;
`else
    localparam logic [31:0] CAUSE_END = 32'h2;
`endif

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic           lock = 1'b1;
    logic           dmreset = 1'b0;
    mapinfo_type    mapinfo;
    dev_config_type cfg;
    apb_in_type     apbi;
    apb_out_type    apbo;
    logic           sys_nrst, dbg_nrst;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] q_d[$];
    logic        q_e[$];
    logic        e_exp;
    int          n;
    logic        d;

    always #5 clk = ~clk;

    apb_prci #(.hold_cycles(16), .sync_stages(2)) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_pll_locked(lock),
        .i_dmreset   (dmreset),
        .i_mapinfo   (mapinfo),
        .o_cfg       (cfg),
        .i_apbi      (apbi),
        .o_apbo      (apbo),
        .o_sys_nrst  (sys_nrst),
        .o_dbg_nrst  (dbg_nrst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // setup phase, access phase (expected response queued), then idle after the accepting edge
    task automatic apb(input logic [11:0] off, input logic [31:0] wdata, input logic w,
                       input logic [31:0] exp_d, input logic exp_e, input logic dm);
        @(negedge clk);
        apbi.paddr   = BASE + 32'(off);
        apbi.pwdata  = wdata;
        apbi.pwrite  = w;
        apbi.psel    = 1'b1;
        apbi.penable = 1'b0;
        @(negedge clk);
        apbi.penable = 1'b1;
        q_d.push_back(exp_d);
        q_e.push_back(exp_e);
        if (dm) dmreset = 1'b1;
        @(negedge clk);
        apbi.psel    = 1'b0;
        apbi.penable = 1'b0;
    endtask

    task automatic rd(input logic [11:0] off, input logic [31:0] exp_d, input logic exp_e);
        apb(off, 32'd0, 1'b0, exp_d, exp_e, 1'b0);
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] data, input logic exp_e);
        apb(off, data, 1'b1, 32'd0, exp_e, 1'b0);
    endtask

    // count clocks until o_sys_nrst rises, dropping i_dmreset after drop_at clocks
    task automatic wait_sys(input int drop_at, output int cnt, output logic dbg_all);
        cnt = 0;
        dbg_all = 1'b1;
        while (!sys_nrst && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == drop_at) dmreset = 1'b0;
            if (!sys_nrst) dbg_all &= dbg_nrst;
        end
    endtask

    // monitor: every pready pulse must match the next queued response
    always @(negedge clk) begin
        if (apbo.pready) begin
            if (q_d.size() == 0) chk("apb_spurious_pready", 32'd1, 32'd0);
            else begin
                e_exp = q_e.pop_front();
                chk("apb_prdata", apbo.prdata, q_d.pop_front());
                chk("apb_pslverr", 32'(apbo.pslverr), 32'(e_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d", passes, checks);
        $fatal(1, "timeout");
    end

    initial begin
        mapinfo = '{addr_start: BASE, addr_end: BASE + 32'hFF};
        apbi = '0;
        tick(5);
        chk("rst_sys_nrst", 32'(sys_nrst), 32'd0);
        chk("rst_dbg_nrst", 32'(dbg_nrst), 32'd0);
        chk("rst_pready", 32'(apbo.pready), 32'd0);
        chk("rst_prdata", apbo.prdata, 32'd0);
        chk("rst_pslverr", 32'(apbo.pslverr), 32'd0);
        chk("cfg_vid", 32'(cfg.vid), 32'h00F1);
        chk("cfg_addr_start", cfg.addr_start, BASE);

        nrst = 1'b1;
        wait_sys(0, n, d);
        chk("por_release_cycles", 32'(n), 32'd19);
        chk("por_dbg_nrst", 32'(dbg_nrst), 32'd1);
        rd(12'h008, 32'h1, 1'b0);
        rd(12'h000, 32'hD, 1'b0);
        rd(12'h00C, 32'd16, 1'b0);
        rd(12'h004, 32'h0, 1'b0);

        wr(12'h004, 32'h1, 1'b0);
        chk("sw_sys_low", 32'(sys_nrst), 32'd0);
        wait_sys(0, n, d);
        chk("sw_low_cycles", 32'(n), 32'd16);
        chk("sw_dbg_held", 32'(d & dbg_nrst), 32'd1);
        rd(12'h008, 32'h4, 1'b0);

        apb(12'h004, 32'h1, 1'b1, 32'd0, 1'b0, 1'b1);
        chk("dm_sys_low", 32'(sys_nrst), 32'd0);
        wait_sys(2, n, d);
        chk("dm_low_cycles", 32'(n), 32'd19);
        chk("dm_dbg_held", 32'(d & dbg_nrst), 32'd1);
        rd(12'h008, 32'h2, 1'b0);

        lock = 1'b0;
        tick(5);
`ifdef PRCI_LOCK_LOSS_RESET_EN
        chk("lockloss_sys", 32'(sys_nrst), 32'd0);
        chk("lockloss_dbg", 32'(dbg_nrst), 32'd0);
        rd(12'h008, 32'h8, 1'b0);
        rd(12'h000, 32'h2, 1'b0);
        lock = 1'b1;
        tick(1);
        wait_sys(0, n, d);
        chk("relock_release_cycles", 32'(n), 32'd18);
        chk("relock_dbg", 32'(dbg_nrst), 32'd1);
        wr(12'h000, 32'h2, 1'b0);
        rd(12'h000, 32'hD, 1'b0);
`else
        chk("lockloss_sys", 32'(sys_nrst), 32'd1);
        chk("lockloss_dbg", 32'(dbg_nrst), 32'd1);
        rd(12'h000, 32'hE, 1'b0);
        wr(12'h000, 32'h2, 1'b0);
        rd(12'h000, 32'hC, 1'b0);
        lock = 1'b1;
        tick(3);
        rd(12'h000, 32'hD, 1'b0);
`endif

        rd(12'h010, 32'h0, 1'b1);
        wr(12'h014, 32'h1, 1'b1);
        tick(2);
        chk("badoff_no_reset", 32'(sys_nrst), 32'd1);
        rd(12'h008, CAUSE_END, 1'b0);

        dmreset = 1'b1;
        tick(2);
        dmreset = 1'b0;
        tick(6);
        chk("hold_pre_dbg", 32'(dbg_nrst), 32'd1);
        chk("hold_pre_sys", 32'(sys_nrst), 32'd0);
        nrst = 1'b0;
        tick(1);
        chk("hold_rst_dbg", 32'(dbg_nrst), 32'd0);
        chk("hold_rst_sys", 32'(sys_nrst), 32'd0);
        chk("hold_rst_pready", 32'(apbo.pready), 32'd0);
        tick(3);
        nrst = 1'b1;
        wait_sys(0, n, d);
        chk("rerelease_cycles", 32'(n), 32'd19);
        rd(12'h008, 32'h1, 1'b0);

        tick(3);
        chk("apb_queue_empty", 32'(q_d.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
